// File: rtl/pc_predict_select.sv
// Fetch-stage PC generator: predicted-PC register, fetch PC select and RUN/RET_WAIT/HALT control.
// Optional performance counters are built only when PC_PERF_CNT_EN is defined.
module pc_predict_select #(
    parameter int              ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int              PRED_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_valid,
    input  logic              f_stall,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic [3:0]        m_icode,
    input  logic              m_cnd,
    input  logic              m_pred_taken,
    input  logic [ADDR_W-1:0] m_valA,
    input  logic [ADDR_W-1:0] m_valC,
    input  logic [3:0]        w_icode,
    input  logic [ADDR_W-1:0] w_valM,
    output logic [ADDR_W-1:0] f_pc,
    output logic              f_pred_taken,
    output logic              mispredict,
    output logic              ret_wait,
    output logic              halted,
    output logic [31:0]       perf_mispred,
    output logic [31:0]       perf_ret
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] pred_pc_r;
    logic              ret_wait_r;
    logic              halted_r;
    logic              mispredict_s;
    logic              w_ret_s;
    logic              f_go_s;
    logic              pred_load_s;
    logic [ADDR_W-1:0] pred_target_s;
    logic              pred_taken_s;
    logic [ADDR_W-1:0] f_pc_s;

    // Redirect detection and fetch-PC priority select.
    always_comb begin
        mispredict_s = (m_icode == 4'h7) && (m_cnd != m_pred_taken);
        w_ret_s      = (w_icode == 4'h9);
        if (mispredict_s) begin
            f_pc_s = m_cnd ? m_valC : m_valA;
        end else if (w_ret_s) begin
            f_pc_s = w_valM;
        end else begin
            f_pc_s = pred_pc_r;
        end
    end

    // Next-PC prediction for the instruction at f_pc.
    always_comb begin
        pred_target_s = f_valP;
        pred_taken_s  = 1'b0;
        case (f_icode)
            4'h7: begin
                if ((PRED_MODE == 0) || (f_valC < f_valP)) begin
                    pred_target_s = f_valC;
                    pred_taken_s  = 1'b1;
                end else begin
                    pred_target_s = f_valP;
                    pred_taken_s  = 1'b0;
                end
            end
            4'h8: begin
                pred_target_s = f_valC;
                pred_taken_s  = 1'b0;
            end
            default: begin
                pred_target_s = f_valP;
                pred_taken_s  = 1'b0;
            end
        endcase
    end

    // Control FSM next state; a mispredict squashes any wrong-path ret or halt.
    always_comb begin
        f_go_s      = f_valid && !f_stall;
        pred_load_s = mispredict_s || w_ret_s || (f_go_s && (state_r == ST_RUN));
        state_nxt_s = state_r;
        if (mispredict_s) begin
            state_nxt_s = ST_RUN;
        end else if ((state_r == ST_RET_WAIT) && w_ret_s) begin
            state_nxt_s = ST_RUN;
        end else if ((state_r == ST_RUN) && f_go_s && (f_icode == 4'h9)) begin
            state_nxt_s = ST_RET_WAIT;
        end else if ((state_r == ST_RUN) && f_go_s && (f_icode == 4'h0)) begin
            state_nxt_s = ST_HALT;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Predicted-PC register, FSM state and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc_r  <= RESET_PC;
            state_r    <= ST_RUN;
            ret_wait_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            if (pred_load_s) begin
                pred_pc_r <= pred_target_s;
            end
            state_r    <= state_nxt_s;
            ret_wait_r <= (state_nxt_s == ST_RET_WAIT);
            halted_r   <= (state_nxt_s == ST_HALT);
        end
    end

`ifdef PC_PERF_CNT_EN
    logic [31:0] perf_mispred_r;
    logic [31:0] perf_ret_r;

    // Saturating event counters, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_mispred_r <= 32'h0;
            perf_ret_r     <= 32'h0;
        end else begin
            if (mispredict_s && (perf_mispred_r != 32'hFFFF_FFFF)) begin
                perf_mispred_r <= perf_mispred_r + 32'd1;
            end
            if (w_ret_s && (perf_ret_r != 32'hFFFF_FFFF)) begin
                perf_ret_r <= perf_ret_r + 32'd1;
            end
        end
    end

    assign perf_mispred = perf_mispred_r;
    assign perf_ret     = perf_ret_r;
`else
    assign perf_mispred = 32'h0;
    assign perf_ret     = 32'h0;
`endif

    assign f_pc         = f_pc_s;
    assign f_pred_taken = pred_taken_s;
    assign mispredict   = mispredict_s;
    assign ret_wait     = ret_wait_r;
    assign halted       = halted_r;

endmodule

// File: tb/tb_pc_predict_select.sv
// Bench for pc_predict_select: always-taken and BTFNT instances driven in parallel,
// directed scenarios followed by random traffic checked against a behavioural model.
module tb_pc_predict_select;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_valid, f_stall, m_cnd, m_pred_taken;
    logic [3:0]  f_icode, m_icode, w_icode;
    logic [63:0] f_valC, f_valP, m_valA, m_valC, w_valM;

    logic [63:0] f_pc0, f_pc1;
    logic        tk0, tk1, mis0, mis1, rw0, rw1, h0, h1;
    logic [31:0] pm0, pm1, pr0, pr1;

    int n_pass = 0;
    int n_total = 0;

    // Model state: pc register and mode (0 run, 1 waiting for ret, 2 halted) per instance
    logic [63:0] mpc [2];
    int          mst [2];
    longint      cnt_mis, cnt_ret;

    always #5 clk = ~clk;

    pc_predict_select #(.ADDR_W(64), .RESET_PC(64'h100), .PRED_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_stall(f_stall), .f_icode(f_icode),
        .f_valC(f_valC), .f_valP(f_valP), .m_icode(m_icode), .m_cnd(m_cnd),
        .m_pred_taken(m_pred_taken), .m_valA(m_valA), .m_valC(m_valC), .w_icode(w_icode),
        .w_valM(w_valM), .f_pc(f_pc0), .f_pred_taken(tk0), .mispredict(mis0),
        .ret_wait(rw0), .halted(h0), .perf_mispred(pm0), .perf_ret(pr0));

    pc_predict_select #(.ADDR_W(64), .RESET_PC(64'h100), .PRED_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_stall(f_stall), .f_icode(f_icode),
        .f_valC(f_valC), .f_valP(f_valP), .m_icode(m_icode), .m_cnd(m_cnd),
        .m_pred_taken(m_pred_taken), .m_valA(m_valA), .m_valC(m_valC), .w_icode(w_icode),
        .w_valM(w_valM), .f_pc(f_pc1), .f_pred_taken(tk1), .mispredict(mis1),
        .ret_wait(rw1), .halted(h1), .perf_mispred(pm1), .perf_ret(pr1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        f_valid = 1'b0; f_stall = 1'b0; f_icode = 4'h1; f_valC = 64'h0; f_valP = 64'h0;
        m_icode = 4'h1; m_cnd = 1'b0; m_pred_taken = 1'b0; m_valA = 64'h0; m_valC = 64'h0;
        w_icode = 4'h1; w_valM = 64'h0;
    endtask

    function automatic logic model_mis();
        return (m_icode == 4'h7) && (m_cnd != m_pred_taken);
    endfunction

    // Where the instruction now at f_pc is predicted to go, per prediction mode
    function automatic logic [63:0] model_target(input int mode);
        if (f_icode == 4'h8) return f_valC;
        if (f_icode != 4'h7) return f_valP;
        if (mode == 0) return f_valC;
        return (f_valC < f_valP) ? f_valC : f_valP;
    endfunction

    function automatic logic model_taken(input int mode);
        if (f_icode != 4'h7) return 1'b0;
        return (mode == 0) || (f_valC < f_valP);
    endfunction

    task automatic check_all();
        logic [63:0] exp_pc;
        logic [63:0] pc_o;
        logic tk_o, mis_o, rw_o, h_o;
        logic [31:0] pm_o, pr_o;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                pc_o = f_pc0; tk_o = tk0; mis_o = mis0; rw_o = rw0; h_o = h0; pm_o = pm0; pr_o = pr0;
            end else begin
                pc_o = f_pc1; tk_o = tk1; mis_o = mis1; rw_o = rw1; h_o = h1; pm_o = pm1; pr_o = pr1;
            end
            if (model_mis()) exp_pc = m_cnd ? m_valC : m_valA;
            else if (w_icode == 4'h9) exp_pc = w_valM;
            else exp_pc = mpc[i];
            chk($sformatf("f_pc[%0d]", i), pc_o, exp_pc);
            chk($sformatf("f_pred_taken[%0d]", i), {63'h0, tk_o}, {63'h0, model_taken(i)});
            chk($sformatf("mispredict[%0d]", i), {63'h0, mis_o}, {63'h0, model_mis()});
            chk($sformatf("ret_wait[%0d]", i), {63'h0, rw_o}, {63'h0, mst[i] == 1});
            chk($sformatf("halted[%0d]", i), {63'h0, h_o}, {63'h0, mst[i] == 2});
`ifdef PC_PERF_CNT_EN
            chk($sformatf("perf_mispred[%0d]", i), {32'h0, pm_o}, cnt_mis[63:0]);
            chk($sformatf("perf_ret[%0d]", i), {32'h0, pr_o}, cnt_ret[63:0]);
`else
            chk($sformatf("perf_mispred[%0d]", i), {32'h0, pm_o}, 64'h0);
            chk($sformatf("perf_ret[%0d]", i), {32'h0, pr_o}, 64'h0);
`endif
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_clock();
        logic mis, ret, go;
        mis = model_mis();
        ret = (w_icode == 4'h9);
        go  = f_valid && !f_stall;
        for (int i = 0; i < 2; i++) begin
            if (mis || ret || (go && mst[i] == 0)) mpc[i] = model_target(i);
            if (mis) mst[i] = 0;
            else if (mst[i] == 1 && ret) mst[i] = 0;
            else if (mst[i] == 0 && go && f_icode == 4'h9) mst[i] = 1;
            else if (mst[i] == 0 && go && f_icode == 4'h0) mst[i] = 2;
        end
        if (mis && cnt_mis < 64'hFFFF_FFFF) cnt_mis++;
        if (ret && cnt_ret < 64'hFFFF_FFFF) cnt_ret++;
    endtask

    // Inputs are applied just after a negedge; check, then clock
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        #2 rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin mpc[i] = 64'h100; mst[i] = 0; end
        cnt_mis = 0; cnt_ret = 0;
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();

        // Always-taken jump prediction, then resolved not-taken
        f_valid = 1'b1; f_icode = 4'h7; f_valC = 64'h40; f_valP = 64'h29;
        #1 chk("t2_taken", {63'h0, tk0}, 64'h1);
        tick();
        idle();
        #1 chk("t2_pred_pc", f_pc0, 64'h40);
        m_icode = 4'h7; m_cnd = 1'b0; m_pred_taken = 1'b1; m_valA = 64'h29; m_valC = 64'h40;
        #1 chk("t2_mispredict", {63'h0, mis0}, 64'h1);
        chk("t2_recover_pc", f_pc0, 64'h29);
        tick();

        // BTFNT forward branch predicted not taken, then resolved taken
        do_reset();
        f_valid = 1'b1; f_icode = 4'h7; f_valC = 64'h80; f_valP = 64'h20;
        #1 chk("t3_not_taken", {63'h0, tk1}, 64'h0);
        tick();
        idle();
        #1 chk("t3_pred_pc", f_pc1, 64'h20);
        m_icode = 4'h7; m_cnd = 1'b1; m_pred_taken = 1'b0; m_valC = 64'h80; m_valA = 64'h20;
        #1 chk("t3_redirect", f_pc1, 64'h80);
        tick();

        // Ret waits three cycles with fetch valid, then returns to w_valM
        do_reset();
        f_valid = 1'b1; f_icode = 4'h9; f_valP = 64'h31;
        tick();
        for (int k = 0; k < 3; k++) begin
            f_icode = 4'h1; f_valP = 64'h999 + 64'(k);
            #1 chk("t4_ret_wait", {63'h0, rw0}, 64'h1);
            chk("t4_pc_held", f_pc0, 64'h31);
            tick();
        end
        w_icode = 4'h9; w_valM = 64'h58; f_icode = 4'h1; f_valP = 64'h5A;
        #1 chk("t4_ret_pc", f_pc0, 64'h58);
        tick();
        idle();
        #1 chk("t4_ret_wait_clr", {63'h0, rw0}, 64'h0);
        chk("t4_after_ret", f_pc0, 64'h5A);
        tick();

        // Wrong-path halt squashed by a mispredict
        do_reset();
        f_valid = 1'b1; f_icode = 4'h0; f_valP = 64'h101;
        tick();
        idle();
        #1 chk("t5_halted", {63'h0, h0}, 64'h1);
        m_icode = 4'h7; m_cnd = 1'b0; m_pred_taken = 1'b1; m_valA = 64'h77;
        #1 chk("t5_pc", f_pc0, 64'h77);
        tick();
        idle();
        #1 chk("t5_unhalt", {63'h0, h0}, 64'h0);
        tick();

        // Three mispredicts and two rets for the counters
        do_reset();
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 3) begin m_icode = 4'h7; m_cnd = k[0]; m_pred_taken = ~k[0]; end
            else begin w_icode = 4'h9; w_valM = 64'h200 + 64'(k); end
            tick();
        end
        idle();
`ifdef PC_PERF_CNT_EN
        #1 chk("t6_perf_mispred", {32'h0, pm0}, 64'd3);
        chk("t6_perf_ret", {32'h0, pr0}, 64'd2);
`else
        #1 chk("t6_perf_mispred", {32'h0, pm0}, 64'd0);
        chk("t6_perf_ret", {32'h0, pr0}, 64'd0);
`endif
        tick();

        // Random traffic with a mid-run reset
        for (int n = 0; n < 500; n++) begin
            if (n == 250) do_reset();
            f_valid = ($urandom_range(0, 3) != 0);
            f_stall = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 11))
                0:       f_icode = 4'h0;
                1, 2, 3: f_icode = 4'h7;
                4:       f_icode = 4'h8;
                5:       f_icode = 4'h9;
                default: f_icode = 4'($urandom_range(1, 6));
            endcase
            f_valC = {32'($urandom), 32'($urandom)};
            f_valP = {32'($urandom), 32'($urandom)};
            m_icode = ($urandom_range(0, 2) == 0) ? 4'h7 : 4'($urandom_range(1, 6));
            m_cnd = 1'($urandom); m_pred_taken = 1'($urandom);
            m_valA = {32'($urandom), 32'($urandom)};
            m_valC = {32'($urandom), 32'($urandom)};
            w_icode = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'($urandom_range(1, 6));
            w_valM = {32'($urandom), 32'($urandom)};
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
